// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO command buffer that sequences ops into a pipelined ALU and returns results in order
module alu_issue_queue #(
    parameter int DEPTH       = 4,
    parameter int ALU_LATENCY = 1,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     cmd_valid_in,
    output logic                     cmd_ready_out,
    input  logic [2:0]               cmd_opcode_in,
    input  logic [DATA_WIDTH-1:0]    cmd_operand1_in,
    input  logic [DATA_WIDTH-1:0]    cmd_operand2_in,
    output logic                     alu_enable_out,
    output logic [2:0]               alu_opcode_out,
    output logic [DATA_WIDTH-1:0]    alu_input1_out,
    output logic [DATA_WIDTH-1:0]    alu_input2_out,
    input  logic [DATA_WIDTH-1:0]    alu_output_in,
    output logic                     result_valid_out,
    input  logic                     result_ready_in,
    output logic [DATA_WIDTH-1:0]    result_data_out,
    output logic [2:0]               result_opcode_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     busy_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = $clog2(ALU_LATENCY + 2);
    localparam int EW = 3 + 2 * DATA_WIDTH;
    typedef enum logic [1:0] {IDLE, WAIT, RESULT} state_t;
    state_t          state;
    logic [EW-1:0]   mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [LW-1:0]   lat;
    logic            push, pop, take;
    // Pop decisions use the registered count, so a fresh push is never bypassed to the ALU.
    assign cmd_ready_out  = (count < CW'(DEPTH)) && !reset_in;
    assign push           = cmd_valid_in && cmd_ready_out;
    assign take           = state == RESULT && result_ready_in;
    assign pop            = count != '0 && (state == IDLE || take);
    assign alu_enable_out = state == WAIT;
    assign count_out      = count;
    assign busy_out       = state != IDLE || count != '0;
    always_ff @(posedge clock_in) begin
        if (push) mem[wr_ptr] <= {cmd_opcode_in, cmd_operand1_in, cmd_operand2_in};
    end
    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            lat               <= '0;
            alu_opcode_out    <= '0;
            alu_input1_out    <= '0;
            alu_input2_out    <= '0;
            result_valid_out  <= 1'b0;
            result_data_out   <= '0;
            result_opcode_out <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop) begin
                {alu_opcode_out, alu_input1_out, alu_input2_out} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PW'(1);
                lat    <= LW'(ALU_LATENCY);
                state  <= WAIT;
            end else if (state == WAIT) begin
                if (lat == '0) begin
                    result_data_out   <= alu_output_in;
                    result_opcode_out <= alu_opcode_out;
                    result_valid_out  <= 1'b1;
                    state             <= RESULT;
                end else begin
                    lat <= lat - LW'(1);
                end
            end else if (take) begin
                state <= IDLE;
            end
            if (take) result_valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: randomized bench with an in-order scoreboard and a one-stage ALU model
module tb_alu_issue_queue;
    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int DW    = 8;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic                  rst, cmd_valid, cmd_ready, alu_en, res_valid, res_ready, busy;
    logic [2:0]            cmd_op, alu_op, res_op;
    logic [DW-1:0]         op1, op2, alu_a, alu_b, res_data;
    logic [DW-1:0]         alu_y = '0;
    logic [$clog2(DEPTH):0] count;
    logic [18:0]           exp_q [$];
    int                    n_checks = 0, n_fail = 0, ncyc = 0;
    alu_issue_queue #(.DEPTH(DEPTH), .ALU_LATENCY(LAT), .DATA_WIDTH(DW)) dut (
        .clock_in(clk), .reset_in(rst),
        .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
        .cmd_opcode_in(cmd_op), .cmd_operand1_in(op1), .cmd_operand2_in(op2),
        .alu_enable_out(alu_en), .alu_opcode_out(alu_op),
        .alu_input1_out(alu_a), .alu_input2_out(alu_b), .alu_output_in(alu_y),
        .result_valid_out(res_valid), .result_ready_in(res_ready),
        .result_data_out(res_data), .result_opcode_out(res_op),
        .count_out(count), .busy_out(busy)
    );
    function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a;
            default: return b;
        endcase
    endfunction
    // Single register stage, matching LAT = 1.
    always @(posedge clk) if (alu_en) alu_y <= alu_f(alu_op, alu_a, alu_b);
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        logic acc, take, hold, was_rst;
        logic [DW-1:0] hd;
        logic [2:0] ho;
        logic [18:0] e;
        #1;
        check("ready_vs_count", cmd_ready, (count < DEPTH) && !rst);
        acc = cmd_valid && cmd_ready;
        take = res_valid && res_ready;
        hold = res_valid && !res_ready;
        was_rst = rst;
        hd = res_data;
        ho = res_op;
        if (take === 1'b1 && !was_rst) begin
            if (exp_q.size() == 0) check("spurious_result", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("result_data", res_data, alu_f(e[18:16], e[15:8], e[7:0]));
                check("result_opcode", res_op, e[18:16]);
            end
        end
        if (acc === 1'b1 && !was_rst) exp_q.push_back({cmd_op, op1, op2});
        @(posedge clk);
        #1;
        ncyc++;
        if (was_rst) exp_q.delete();
        else begin
            if (hold === 1'b1) begin
                check("hold_valid", res_valid, 1);
                check("hold_data", res_data, hd);
                check("hold_opcode", res_op, ho);
            end
            if (alu_en === 1'b1) begin
                if (exp_q.size() == 0) check("inflight_missing", 1, 0);
                else check("alu_inputs", {alu_op, alu_a, alu_b}, exp_q[0]);
            end
        end
        if (ncyc > 20000) begin
            $display("FAIL watchdog: got %0d cycles expected fewer than 20000", ncyc);
            $fatal(1);
        end
    endtask
    task automatic send(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic got = 1'b0;
        cmd_op = op; op1 = a; op2 = b; cmd_valid = 1'b1;
        for (int t = 0; t < 40 && !got; t++) begin
            got = cmd_ready;
            cyc();
        end
        cmd_valid = 1'b0;
        if (!got) check("send_timeout", 0, 1);
    endtask
    task automatic drain();
        cmd_valid = 1'b0;
        for (int t = 0; t < 300 && (exp_q.size() != 0 || busy); t++) begin
            res_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        check("drain_done", {exp_q.size() == 0, busy}, 2'b10);
        check("drain_count", count, 0);
    endtask
    initial begin
        int n_acc;
        int times [$];
        logic got;
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd0; op1 = 8'd1; op2 = 8'd2; res_ready = 1'b1;
        cyc();
        cyc();
        check("rst_outputs", {alu_en, alu_op, alu_a, alu_b, res_valid, res_data, res_op, count, busy}, 0);
        check("rst_ready", cmd_ready, 0);
        rst = 1'b0; cmd_valid = 1'b0;
        #1;
        check("ready_after_rst", cmd_ready, 1);
        check("count_after_rst", count, 0);
        repeat (5) cyc();
        check("no_result_after_rst", res_valid, 0);
        res_ready = 1'b0; cmd_op = 3'd0; op1 = 8'd10; op2 = 8'd15; cmd_valid = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        check("k_count", count, 1);
        check("k_enable", alu_en, 0);
        cyc();
        check("k1_enable", alu_en, 1);
        check("k1_operands", {alu_a, alu_b}, {8'd10, 8'd15});
        check("k1_count", count, 0);
        cyc();
        check("k2_enable", alu_en, 1);
        check("k2_operands", {alu_a, alu_b}, {8'd10, 8'd15});
        check("k2_valid", res_valid, 0);
        cyc();
        check("k3_enable", alu_en, 0);
        check("k3_valid", res_valid, 1);
        check("k3_data", res_data, 25);
        check("k3_opcode", res_op, 0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("single_done_valid", res_valid, 0);
        check("single_done_busy", busy, 0);
        n_acc = 0;
        for (int i = 10; i <= 15; i++) begin
            cmd_op = 3'd0; op1 = DW'(i); op2 = 8'd15; cmd_valid = 1'b1; got = 1'b0;
            for (int t = 0; t < 20 && !got; t++) begin
                got = cmd_ready;
                cyc();
            end
            if (got) n_acc++;
        end
        cmd_valid = 1'b0;
        check("fill_accepted", n_acc, 5);
        check("fill_ready", cmd_ready, 0);
        check("fill_count", count, 4);
        check("fill_data", res_data, 25);
        res_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (res_valid) times.push_back(ncyc);
            cyc();
        end
        check("drain_results", times.size(), 5);
        for (int i = 1; i < times.size(); i++) check("drain_spacing", times[i] - times[i-1], 3);
        check("drain_busy", busy, 0);
        check("drain_count", count, 0);
        send(3'd0, 8'd255, 8'd1);
        send(3'd0, 8'd200, 8'd100);
        drain();
        for (int r = 0; r < 3; r++) begin
            for (int t = 0; t < 150; t++) begin
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_op = 3'($urandom_range(0, 7));
                op1 = DW'($urandom);
                op2 = DW'($urandom);
                res_ready = (r == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
                cyc();
            end
            drain();
        end
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(3'(i), DW'(20 + i), DW'(3 * i));
        repeat (3) cyc();
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        check("midop_enable", alu_en, 1);
        check("midop_count", count, 3);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("midop_rst_count", count, 0);
        check("midop_rst_enable", alu_en, 0);
        check("midop_rst_valid", res_valid, 0);
        res_ready = 1'b1;
        for (int t = 0; t < 8; t++) begin
            cyc();
            check("midop_no_result", res_valid, 0);
        end
        send(3'd1, 8'd50, 8'd8);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
